// File: rtl/spi_pkg.sv
// Shared constants for the SPI initiator: one-hot state encoding, default widths,
// and the R/W bit encoding.
package spi_pkg;

  localparam int unsigned ADDR_WIDTH_DEF = 7;
  localparam int unsigned DATA_WIDTH_DEF = 8;

  localparam logic SPI_READ  = 1'b1;
  localparam logic SPI_WRITE = 1'b0;

  typedef enum logic [7:0] {
    ST_IDLE  = 8'b0000_0001,
    ST_LEAD  = 8'b0000_0010,
    ST_ADDR  = 8'b0000_0100,
    ST_RW    = 8'b0000_1000,
    ST_WDATA = 8'b0001_0000,
    ST_TURN  = 8'b0010_0000,
    ST_RDATA = 8'b0100_0000,
    ST_TAIL  = 8'b1000_0000
  } state_t;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/spi_sclk_gen.sv
// SPI clock divider: toggles sclk every CLK_DIV clk cycles while enabled, with
// one-cycle tick pulses in the clk cycle before each sclk edge.
module spi_sclk_gen #(
  parameter int unsigned CLK_DIV = 50
) (
  input  logic clk,
  input  logic reset_n,
  input  logic enable,
  output logic sclk,
  output logic rise_tick,
  output logic fall_tick
);

  localparam int unsigned CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] TERM = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt;
  logic          term;

  // Divider and sclk are held cleared whenever the master is idle.
  always_ff @(posedge clk) begin
    if (!reset_n || !enable) begin
      cnt  <= '0;
      sclk <= 1'b0;
    end else if (cnt == TERM) begin
      cnt  <= '0;
      sclk <= ~sclk;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign term      = enable && (cnt == TERM);
  assign rise_tick = term && !sclk;
  assign fall_tick = term && sclk;

endmodule

// File: rtl/spi_master.sv
// SPI initiator: address MSB first, R/W bit, then 8 data bits out (write) or in
// (read), framed by a lead period with cs high and a trailing cs-high period.
module spi_master
  import spi_pkg::*;
#(
  parameter int unsigned CLK_DIV         = 50,
  parameter int unsigned ADDR_WIDTH      = ADDR_WIDTH_DEF,
  parameter int unsigned DATA_WIDTH      = DATA_WIDTH_DEF,
  parameter int unsigned READ_TURNAROUND = 1,
  parameter int unsigned CS_IDLE_CYCLES  = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic                  rw,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  sclk,
  output logic                  cs,
  output logic                  mosi,
  input  logic                  miso
);

  localparam int unsigned TX_W        = ADDR_WIDTH + 1 + DATA_WIDTH;
  localparam int unsigned MAX_PERIODS = max_u(max_u(ADDR_WIDTH, DATA_WIDTH),
                                              max_u(max_u(READ_TURNAROUND, CS_IDLE_CYCLES), 1));
  localparam int unsigned CNT_W       = $clog2(MAX_PERIODS + 1);

  state_t                state;
  logic                  rw_q;
  logic [TX_W-1:0]       tx;
  logic [DATA_WIDTH-1:0] rx;
  logic [DATA_WIDTH-1:0] rx_shift;
  logic [CNT_W-1:0]      bit_cnt;
  logic                  rise_tick;
  logic                  fall_tick;
  logic                  unused_rise;

  spi_sclk_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_sclk_gen (
    .clk       (clk),
    .reset_n   (reset_n),
    .enable    (busy),
    .sclk      (sclk),
    .rise_tick (rise_tick),
    .fall_tick (fall_tick)
  );

  // Every state advances on the tick ending a high phase; the rising edge is not needed here.
  assign unused_rise = rise_tick;
  assign rx_shift    = (rx << 1) | DATA_WIDTH'(miso);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state   <= ST_IDLE;
      cs      <= 1'b1;
      mosi    <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      rdata   <= '0;
      rw_q    <= SPI_WRITE;
      tx      <= '0;
      rx      <= '0;
      bit_cnt <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            rw_q    <= rw;
            tx      <= {addr, rw, wdata};
            busy    <= 1'b1;
            bit_cnt <= '0;
            state   <= ST_LEAD;
          end
        end
        ST_LEAD: begin
          if (fall_tick) begin
            cs      <= 1'b0;
            mosi    <= tx[TX_W-1];
            tx      <= tx << 1;
            bit_cnt <= CNT_W'(ADDR_WIDTH - 1);
            state   <= ST_ADDR;
          end
        end
        // The last address fall already presents the R/W bit.
        ST_ADDR: begin
          if (fall_tick) begin
            mosi <= tx[TX_W-1];
            tx   <= tx << 1;
            if (bit_cnt == '0) begin
              state <= ST_RW;
            end else begin
              bit_cnt <= bit_cnt - CNT_W'(1);
            end
          end
        end
        ST_RW: begin
          if (fall_tick) begin
            if (rw_q == SPI_WRITE) begin
              mosi    <= tx[TX_W-1];
              tx      <= tx << 1;
              bit_cnt <= CNT_W'(DATA_WIDTH - 1);
              state   <= ST_WDATA;
            end else begin
              mosi <= 1'b0;
              if (READ_TURNAROUND == 0) begin
                bit_cnt <= CNT_W'(DATA_WIDTH - 1);
                state   <= ST_RDATA;
              end else begin
                bit_cnt <= CNT_W'(READ_TURNAROUND - 1);
                state   <= ST_TURN;
              end
            end
          end
        end
        ST_WDATA: begin
          if (fall_tick) begin
            if (bit_cnt == '0) begin
              cs      <= 1'b1;
              mosi    <= 1'b0;
              bit_cnt <= CNT_W'(CS_IDLE_CYCLES - 1);
              if (CS_IDLE_CYCLES == 0) begin
                busy  <= 1'b0;
                done  <= 1'b1;
                state <= ST_IDLE;
              end else begin
                state <= ST_TAIL;
              end
            end else begin
              mosi    <= tx[TX_W-1];
              tx      <= tx << 1;
              bit_cnt <= bit_cnt - CNT_W'(1);
            end
          end
        end
        ST_TURN: begin
          if (fall_tick) begin
            if (bit_cnt == '0) begin
              bit_cnt <= CNT_W'(DATA_WIDTH - 1);
              state   <= ST_RDATA;
            end else begin
              bit_cnt <= bit_cnt - CNT_W'(1);
            end
          end
        end
        // miso is taken in the last clk cycle of the high phase.
        ST_RDATA: begin
          if (fall_tick) begin
            rx <= rx_shift;
            if (bit_cnt == '0) begin
              cs      <= 1'b1;
              mosi    <= 1'b0;
              bit_cnt <= CNT_W'(CS_IDLE_CYCLES - 1);
              if (CS_IDLE_CYCLES == 0) begin
                busy  <= 1'b0;
                done  <= 1'b1;
                rdata <= rx_shift;
                state <= ST_IDLE;
              end else begin
                state <= ST_TAIL;
              end
            end else begin
              bit_cnt <= bit_cnt - CNT_W'(1);
            end
          end
        end
        ST_TAIL: begin
          if (fall_tick) begin
            if (bit_cnt == '0) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= ST_IDLE;
              if (rw_q == SPI_READ) begin
                rdata <= rx;
              end
            end else begin
              bit_cnt <= bit_cnt - CNT_W'(1);
            end
          end
        end
        default: begin
          state <= ST_IDLE;
          cs    <= 1'b1;
          mosi  <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/spi_master.md
Name: spi_master

Overview:
SPI initiator that drives the chip-select/sclk/mosi lines of spimemory and captures miso. One transaction is a 7-bit address, MSB first, then a R/W bit (1=read, 0=write), then 8 data bits. On a write the master sends the data; on a read it receives it. Sits between a host/register interface on the system clock and the off-block SPI pins, and replaces hand-driven bench stimulus for spimemory.

Parameters:
CLK_DIV, 50, clk cycles per sclk half-period (legal range ≥1).
ADDR_WIDTH, 7, address bits shifted out.
DATA_WIDTH, 8, data bits per transfer.
READ_TURNAROUND, 1, sclk periods after the R/W bit before the first read-data sample (slave load cycle).
CS_IDLE_CYCLES, 1, sclk periods cs is held high after the last data bit.

Ports:
clk  input  1  system clock, all logic on rising edge
reset_n  input  1  synchronous active-low reset
start  input  1  request pulse, sampled only when busy=0
rw  input  1  1=read, 0=write; latched with start
addr  input  ADDR_WIDTH  target address; latched with start
wdata  input  DATA_WIDTH  write data; latched with start
busy  output  1  high from cycle after accepted start until done
done  output  1  one-cycle completion pulse
rdata  output  DATA_WIDTH  last read result, held until next read completes
sclk  output  1  SPI clock, idles low
cs  output  1  chip select, active low, idles high
mosi  output  1  serial data to slave
miso  input  1  serial data from slave

Behaviour:
- Reset (reset_n=0 at clk edge): state IDLE; cs=1, sclk=0, mosi=0, busy=0, done=0, rdata=0, divider cleared. This also applies mid-transaction, and any partial transfer is abandoned.
- The divider counts 0..CLK_DIV-1 and emits a toggle tick on terminal count. It runs only while busy.
- Bit period = 2*CLK_DIV clk cycles: low phase then high phase.
- mosi changes only at the start of a low phase. The slave samples on the sclk rising edge.
- miso is sampled on the last clk cycle of the high phase, before the falling edge. Read data is MSB first into a shift register.
- States are one-hot: IDLE, LEAD, ADDR, RW, WDATA, TURN, RDATA, TAIL.
- IDLE: if start, latch rw/addr/wdata and go to LEAD. busy=1 from the next cycle. start while busy is ignored and its inputs are not latched.
- LEAD: 1 sclk period with cs=1 and sclk toggling. This lets the slave FSM reach its start state. Then cs=0 and go to ADDR.
- ADDR: ADDR_WIDTH periods, mosi=addr MSB..LSB.
- RW: 1 period, mosi=rw. Then WDATA if rw=0, or TURN if rw=1.
- WDATA: DATA_WIDTH periods, mosi=wdata MSB..LSB.
- TURN: READ_TURNAROUND periods, mosi=0. If READ_TURNAROUND=0, go straight to RDATA.
- RDATA: DATA_WIDTH periods, mosi=0, shifting miso in.
- TAIL: cs=1, sclk keeps toggling for CS_IDLE_CYCLES periods, mosi=0.
- At the end of TAIL: sclk=0, busy=0, done=1 for exactly one cycle, state=IDLE.
  - On a read, rdata takes the shift-register value in the same cycle done rises. On a write, rdata is unchanged.
  - start in the done cycle is accepted (back-to-back).
- Latency from the start-accept cycle to done:
  - write: (2+ADDR_WIDTH+DATA_WIDTH+CS_IDLE_CYCLES)*2*CLK_DIV cycles.
  - read: add READ_TURNAROUND*2*CLK_DIV.
- Counters are sized by $clog2 of max+1. The bit counter reloads at every state entry.

Decomposition:
- spi_pkg: one-hot state constants (8 states), default widths, R/W encoding constants (SPI_READ=1, SPI_WRITE=0).
- Sub-module spi_sclk_gen: parameter CLK_DIV; inputs clk, reset_n, enable; outputs sclk, rise_tick, fall_tick (one-cycle pulses on the clk cycle before each edge).
- The FSM, shift registers and bit counter stay in spi_master.

Test Plan:
1. CLK_DIV=2, write addr=7'h00 wdata=8'hAA with spimemory attached:
   - done exactly 72 cycles after start.
   - dut memory[0]=8'hAA.
   - mosi bit stream on sclk rises: 0000000_0_10101010.
2. Read addr=7'h00 after scenario 1 → rdata=8'hAA on done, at 76 cycles.
3. Read against a behavioural slave driving miso = 8'h5C MSB first, addr=7'h55 → mosi address bits 1010101, R/W=1, rdata=8'h5C.
4. Pulse start with addr=7'h7F during busy → ignored; the current transfer's bits and rdata are unaffected, and no extra done.
5. Assert reset_n=0 for 1 cycle mid-ADDR → next cycle cs=1, sclk=0, busy=0, rdata=0. A new write then completes normally.
6. CLK_DIV=1, start held high through done → second transaction begins in the done cycle. sclk period is exactly 2 clk, and two done pulses are spaced by the full latency.
